// File: rtl/nand_seq_ctrl.sv
// nand_seq_ctrl: steps vectors 0..LAST_VEC into the NAND lab block and checks e/f/g against a gate-level reference; HALT_ON_FAIL_EN stops at the first mismatch.
// Latency: SETTLE_CYC+2 cycles per vector, (LAST_VEC+1)*(SETTLE_CYC+2) cycles from first DRIVE to done.
// Backpressure: none; start is ignored while busy and only rst_n aborts a run.
module nand_seq_ctrl #(
    parameter int SETTLE_CYC = 2,
    parameter int LAST_VEC   = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a_o,
    output logic       b_o,
    output logic       c_o,
    output logic       d_o,
    input  logic       e_i,
    input  logic       f_i,
    input  logic       g_i,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_cnt,
    output logic [3:0] first_fail,
    output logic       first_fail_vld
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DRIVE  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_CHECK  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC - 1);
    localparam logic [3:0] LAST_IDX  = 4'(LAST_VEC);

    logic [2:0] state;
    logic [3:0] idx;
    logic [3:0] settle_cnt;

    logic exp_e;
    logic exp_f;
    logic exp_g;
    logic mismatch;
    logic run_end;

    // Reference is taken from the driven pins, which equal idx throughout CHECK.
    always_comb begin
        exp_e    = ~(a_o & b_o);
        exp_f    = ~(c_o & d_o);
        exp_g    = ~(exp_e & exp_f);
        mismatch = (e_i != exp_e) | (f_i != exp_f) | (g_i != exp_g);
`ifdef HALT_ON_FAIL_EN
        run_end  = mismatch | (idx == LAST_IDX);
`else
        run_end  = (idx == LAST_IDX);
`endif
    end

    assign pass = done & (err_cnt == 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            idx            <= 4'd0;
            settle_cnt     <= 4'd0;
            a_o            <= 1'b0;
            b_o            <= 1'b0;
            c_o            <= 1'b0;
            d_o            <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_cnt        <= 5'd0;
            first_fail     <= 4'd0;
            first_fail_vld <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state          <= ST_DRIVE;
                        idx            <= 4'd0;
                        err_cnt        <= 5'd0;
                        first_fail     <= 4'd0;
                        first_fail_vld <= 1'b0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    {d_o, c_o, b_o, a_o} <= idx;
                    settle_cnt           <= SETTLE_LD;
                    state                <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        state <= ST_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        if (err_cnt != 5'd16) begin
                            err_cnt <= err_cnt + 5'd1;
                        end
                        if (!first_fail_vld) begin
                            first_fail     <= idx;
                            first_fail_vld <= 1'b1;
                        end
                    end
                    if (run_end) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        idx   <= idx + 4'd1;
                        state <= ST_DRIVE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nand_seq_ctrl.sv
// Bench for nand_seq_ctrl: two instances (default and SETTLE_CYC=1/LAST_VEC=3) driving bench-side NAND models with injectable faults.
module tb_nand_seq_ctrl;

    localparam int S0 = 2;
    localparam int L0 = 15;
    localparam int S1 = 1;
    localparam int L1 = 3;
`ifdef HALT_ON_FAIL_EN
    localparam bit HALT = 1'b1;
`else
    localparam bit HALT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] a_o, b_o, c_o, d_o, e_i, f_i, g_i;
    logic [1:0] busy, done, pass, first_fail_vld;
    logic [4:0] err_cnt [2];
    logic [3:0] first_fail [2];
    logic [3:0] vin0, vin1;

    int         fault_mode = 0;
    logic [2:0] mask [16];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Behavioural model state, one slot per instance
    int m_busy [2] = '{0, 0};
    int m_done [2] = '{0, 0};
    int m_err  [2] = '{0, 0};
    int m_ff   [2] = '{0, 0};
    int m_ffv  [2] = '{0, 0};
    int m_vec  [2] = '{0, 0};
    int m_k    [2] = '{0, 0};
    int mv, mph, mper;
    bit mm;

    always #5 clk = ~clk;

    assign vin0 = {d_o[0], c_o[0], b_o[0], a_o[0]};
    assign vin1 = {d_o[1], c_o[1], b_o[1], a_o[1]};

    // NAND block as wired on the board, optionally faulted
    function automatic logic [2:0] resp(input logic [3:0] v, input int fm, input logic [2:0] mk);
        logic e, f, g;
        e = ~(v[0] & v[1]);
        f = ~(v[2] & v[3]);
        g = ~(e & f);
        case (fm)
            1:       return {e, f, 1'b0};
            2:       return {e, f, g} ^ mk;
            default: return {e, f, g};
        endcase
    endfunction

    assign {e_i[0], f_i[0], g_i[0]} = resp(vin0, fault_mode, mask[vin0]);
    assign {e_i[1], f_i[1], g_i[1]} = resp(vin1, fault_mode, mask[vin1]);

    nand_seq_ctrl #(.SETTLE_CYC(S0), .LAST_VEC(L0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_o(a_o[0]), .b_o(b_o[0]), .c_o(c_o[0]), .d_o(d_o[0]),
        .e_i(e_i[0]), .f_i(f_i[0]), .g_i(g_i[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_cnt(err_cnt[0]), .first_fail(first_fail[0]), .first_fail_vld(first_fail_vld[0])
    );

    nand_seq_ctrl #(.SETTLE_CYC(S1), .LAST_VEC(L1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_o(a_o[1]), .b_o(b_o[1]), .c_o(c_o[1]), .d_o(d_o[1]),
        .e_i(e_i[1]), .f_i(f_i[1]), .g_i(g_i[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_cnt(err_cnt[1]), .first_fail(first_fail[1]), .first_fail_vld(first_fail_vld[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int per_of(input int i);
        return (i == 0) ? S0 + 2 : S1 + 2;
    endfunction

    function automatic int last_of(input int i);
        return (i == 0) ? L0 : L1;
    endfunction

    // A vector is bad when the faulted block disagrees with the NAND truth table
    function automatic bit bad(input int v);
        logic [3:0] vv;
        vv = v[3:0];
        case (fault_mode)
            1:       return (vv[0] & vv[1]) | (vv[2] & vv[3]);
            2:       return mask[vv] != 3'd0;
            default: return 1'b0;
        endcase
    endfunction

    // Model: a run is a cycle count k; vector = k / period, phase = k % period
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    m_busy[i] = 0; m_done[i] = 0; m_err[i] = 0;
                    m_ff[i] = 0; m_ffv[i] = 0; m_vec[i] = 0; m_k[i] = 0;
                end else if (m_busy[i] == 0) begin
                    if (start) begin
                        m_busy[i] = 1; m_done[i] = 0; m_err[i] = 0;
                        m_ff[i] = 0; m_ffv[i] = 0; m_k[i] = 0;
                    end
                end else begin
                    mper = per_of(i);
                    mv   = m_k[i] / mper;
                    mph  = m_k[i] % mper;
                    if (mph == 0) m_vec[i] = mv;
                    if (mph == mper - 1) begin
                        mm = bad(mv);
                        if (mm) begin
                            m_err[i]++;
                            if (m_ffv[i] == 0) begin
                                m_ff[i] = mv;
                                m_ffv[i] = 1;
                            end
                        end
                        if (mv == last_of(i) || (HALT && mm)) begin
                            m_busy[i] = 0;
                            m_done[i] = 1;
                        end
                    end
                    m_k[i]++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("c%0d u%0d busy", cyc, i), busy[i], m_busy[i]);
                chk($sformatf("c%0d u%0d done", cyc, i), done[i], m_done[i]);
                chk($sformatf("c%0d u%0d pass", cyc, i), pass[i], int'(m_done[i] == 1 && m_err[i] == 0));
                chk($sformatf("c%0d u%0d err_cnt", cyc, i), err_cnt[i], m_err[i]);
                chk($sformatf("c%0d u%0d first_fail", cyc, i), first_fail[i], m_ff[i]);
                chk($sformatf("c%0d u%0d first_fail_vld", cyc, i), first_fail_vld[i], m_ffv[i]);
                chk($sformatf("c%0d u%0d vec", cyc, i), (i == 0) ? vin0 : vin1, m_vec[i]);
            end
        end
    end

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while ((busy[0] || busy[1]) && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (busy[0] || busy[1]) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: busy=%b after %0d cycles, expected 00", busy, bound);
        end
    endtask

    // One start pulse; optional extra start at cycle mid_at, optional reset at cycle rst_at
    task automatic run_dir(input int fm, input int mid_at, input int rst_at,
                           output int bc0, output int bc1);
        bc0 = 0;
        bc1 = 0;
        fault_mode = fm;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (busy[0]) bc0++;
            if (busy[1]) bc1++;
            if (i == rst_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk("async_rst busy", busy[0], 0);
                chk("async_rst vec", vin0, 0);
                chk("async_rst err_cnt", err_cnt[0], 0);
                chk("async_rst done", done[0], 0);
                repeat (2) @(negedge clk);
                #2 rst_n = 1'b1;
                return;
            end
            start = (i == mid_at);
            if (!busy[0] && !busy[1]) return;
            @(negedge clk);
        end
        tests++;
        fails++;
        $display("FAIL run_timeout: busy=%b after 200 cycles, expected 00", busy);
    endtask

    int bc0, bc1, sc;

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        for (int j = 0; j < 16; j++) mask[j] = 3'd0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy", busy[0], 0);
        chk("reset done", done[0], 0);
        chk("reset pass", pass[0], 0);
        chk("reset vec", vin0, 0);
        chk("reset err_cnt", err_cnt[0], 0);
        #2 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle busy", busy[0], 0);
        chk("idle vec", vin0, 0);

        run_dir(0, -1, -1, bc0, bc1);
        chk("good busy_cycles", bc0, 64);
        chk("small busy_cycles", bc1, 12);
        chk("good done", done[0], 1);
        chk("good pass", pass[0], 1);
        chk("good err_cnt", err_cnt[0], 0);
        chk("good ffv", first_fail_vld[0], 0);
        chk("good last_vec", vin0, 15);
        chk("small pass", pass[1], 1);

        run_dir(1, -1, -1, bc0, bc1);
`ifdef HALT_ON_FAIL_EN
        chk("gstuck err_cnt", err_cnt[0], 1);
        chk("gstuck busy_cycles", bc0, 16);
        chk("gstuck held_vec", vin0, 3);
`else
        chk("gstuck err_cnt", err_cnt[0], 7);
        chk("gstuck busy_cycles", bc0, 64);
`endif
        chk("gstuck first_fail", first_fail[0], 3);
        chk("gstuck ffv", first_fail_vld[0], 1);
        chk("gstuck pass", pass[0], 0);
        chk("small gstuck err_cnt", err_cnt[1], 1);
        chk("small gstuck first_fail", first_fail[1], 3);

        run_dir(0, 21, -1, bc0, bc1);
        chk("midstart busy_cycles", bc0, 64);
        chk("midstart pass", pass[0], 1);

        run_dir(0, -1, 38, bc0, bc1);
        run_dir(0, -1, -1, bc0, bc1);
        chk("post_rst busy_cycles", bc0, 64);
        chk("post_rst pass", pass[0], 1);
        chk("post_rst err_cnt", err_cnt[0], 0);

        for (int it = 0; it < 40; it++) begin
            fault_mode = $urandom_range(0, 2);
            for (int j = 0; j < 16; j++)
                mask[j] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            sc = $urandom_range(0, 9);
            if (sc < 6) begin
                start = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                for (int n = 0; n < 80; n++) begin
                    start = ($urandom_range(0, 7) == 0);
                    @(negedge clk);
                end
                start = 1'b0;
                wait_idle(200);
            end else if (sc < 8) begin
                start = 1'b1;
                repeat ($urandom_range(60, 160)) @(negedge clk);
                start = 1'b0;
                wait_idle(200);
            end else begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                repeat ($urandom_range(1, 60)) @(negedge clk);
                #2 rst_n = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                #2 rst_n = 1'b1;
                @(negedge clk);
            end
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nand_seq_ctrl.md
Name: nand_seq_ctrl

Overview:
Self-checking sequencer for the 4-input/3-output NAND lab block (inputs a,b,c,d; outputs e,f,g). On a start pulse it drives all 16 input combinations onto the block, waits a programmable settle time, and compares each response against a built-in gate-level reference. It sits between the board I/O (start button, LEDs) and the NAND instance, replacing free-running toggle stimulus with clocked, checked stepping.

Parameters:
SETTLE_CYC, 2, number of clock cycles the vector is held before the result is sampled (legal range 1..15)
LAST_VEC, 15, index of the final vector applied (legal range 0..15)

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a run; sampled only in IDLE and DONE
a_o  output  1  drive to NAND input a (vector bit 0)
b_o  output  1  drive to NAND input b (vector bit 1)
c_o  output  1  drive to NAND input c (vector bit 2)
d_o  output  1  drive to NAND input d (vector bit 3)
e_i  input  1  NAND output e
f_i  input  1  NAND output f
g_i  input  1  NAND output g
busy  output  1  run in progress
done  output  1  run complete; held until next start
pass  output  1  valid while done=1; 1 = zero mismatches
err_cnt  output  5  mismatching vectors in the current or last run (0..16)
first_fail  output  4  index of first mismatching vector
first_fail_vld  output  1  first_fail holds a captured index

Behaviour:
- One clock, clk; rst_n asynchronous active-low; every flop clears on rst_n=0 regardless of clk.
- Reset values: all outputs 0; FSM in IDLE; vector index 0; settle counter 0.
- Reference function: exp_e = ~(a&b), exp_f = ~(c&d), exp_g = ~(exp_e & exp_f). A vector mismatches when any of e_i/f_i/g_i differs from its expected value.
- Vector mapping: idx[3:0] -> {d_o,c_o,b_o,a_o}; a_o toggles fastest.
- FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE: outputs a_o..d_o = 0. start=1 -> DRIVE; idx<=0, err_cnt<=0, first_fail_vld<=0, first_fail<=0, busy<=1.
- DRIVE (1 cycle): a_o..d_o registered from idx; settle counter <= SETTLE_CYC-1; -> SETTLE.
- SETTLE: count down; when counter==0 -> CHECK. Holds for exactly SETTLE_CYC cycles.
- CHECK (1 cycle): compare. On mismatch, err_cnt += 1; if first_fail_vld=0, first_fail<=idx, first_fail_vld<=1. If idx==LAST_VEC -> DONE; otherwise idx+1 -> DRIVE.
- Per-vector cost: SETTLE_CYC+2 cycles. Full run with defaults: 16 x 4 = 64 cycles from first DRIVE to DONE entry.
- DONE: busy=0, done=1, pass=(err_cnt==0); a_o..d_o hold the last vector. start=1 -> same actions as IDLE start (restarts; done drops the next cycle).
- start is ignored in DRIVE/SETTLE/CHECK; no abort mid-run except through reset.
- err_cnt never wraps (max 16 fits in 5 bits).
- rst_n asserted mid-run: immediately returns to IDLE with reset values; partial results are discarded.
- start held high continuously: one run per DONE entry; DONE lasts exactly 1 cycle before the restart.
- pass is 0 whenever done=0.

Optional Feature:
HALT_ON_FAIL_EN. Defined: CHECK with a mismatch goes straight to DONE (pass=0, err_cnt=1, first_fail=failing idx); a_o..d_o keep the failing vector for probing. Undefined: all vectors up to LAST_VEC are always applied and err_cnt counts every mismatch.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles, release, start=0 for 20 cycles -> all outputs 0, busy=0.
- Correct NAND block, start pulse -> busy for 64 cycles; a_o..d_o step 0..15 every 4 cycles; done=1, pass=1, err_cnt=0, first_fail_vld=0.
- Faulty model with g stuck at 0 -> err_cnt=7 (exp_g=1 only for vectors 3,7,11,12,13,14,15), first_fail=3, pass=0; with HALT_ON_FAIL_EN -> DONE after vector 3, err_cnt=1, {d,c,b,a}=0011.
- start pulsed mid-run at vector 5 -> ignored; run completes normally at 64 cycles.
- rst_n low during vector 9 -> outputs clear asynchronously within the same cycle; a new start gives a full clean run.
- SETTLE_CYC=1, LAST_VEC=3 -> 4 vectors at 3 cycles each, done after 12 cycles, pass=1.
